// File: rtl/pipelined_carry_adder_if.sv
// Streaming operand/result bus of the pipelined carry adder.
// The master side supplies operands and accepts results; the slave side is the adder.
interface pipelined_carry_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic             Cout;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, Y, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, Y, Cout, Ovf
  );
endinterface

// File: rtl/pipelined_carry_adder.sv
// Pipelined WIDTH-bit add/subtract unit with valid/ready streaming handshakes.
// The word is split into STAGES chunks of CW bits; stage k adds chunk k and
// registers its carry for stage k+1, so latency equals STAGES cycles.
//
// Each stage keeps one WIDTH-bit "rotating" word: the lowest CW bits are the
// A chunk the stage is about to add, and each stage drops that chunk and
// pushes its freshly computed sum chunk in at the top. After the last stage
// the word holds the finished sum in natural bit order. The B_eff chunks that
// are still to be added shrink by one chunk per stage.
//
// The whole pipeline advances on a single enable (no bubble collapsing), so
// in_ready depends only on out_valid/out_ready.
// WIDTH must be a multiple of STAGES, and STAGES >= 1.
module pipelined_carry_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipelined_carry_adder_if.slave bus
);

  localparam int CW = WIDTH / STAGES;

  // Chunk adder: returns {carry_out, sum} of a + b + ci.
  function automatic logic [CW:0] add_chunk(
    input logic [CW-1:0] a_v,
    input logic [CW-1:0] b_v,
    input logic          ci_v
  );
    logic [CW:0] acc_v;
    acc_v = {1'b0, a_v} + {1'b0, b_v} + {{CW{1'b0}}, ci_v};
    return acc_v;
  endfunction

  logic             en_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             c0_s;
  logic             ovf_nxt_s;
  logic             ovf_r;

  // Operand conditioning: subtract is A + ~B + 1, so Cin is ignored then.
  always_comb begin
    if (bus.Sub) begin
      b_eff_s = ~bus.B;
      c0_s    = 1'b1;
    end else begin
      b_eff_s = bus.B;
      c0_s    = bus.Cin;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Number of B_eff bits not yet added when entering this stage.
    localparam int BW = WIDTH - k * CW;

    logic [WIDTH-1:0] w_in_s;
    logic [BW-1:0]    b_in_s;
    logic             c_in_s;
    logic             v_in_s;
    logic [CW:0]      add_s;
    logic [WIDTH-1:0] w_nxt_s;
    logic [WIDTH-1:0] w_r;
    logic             c_r;
    logic             v_r;

    if (k == 0) begin : g_src
      assign w_in_s = bus.A;
      assign b_in_s = b_eff_s;
      assign c_in_s = c0_s;
      assign v_in_s = bus.in_valid;
    end else begin : g_src
      assign w_in_s = g_stage[k-1].w_r;
      assign b_in_s = g_stage[k-1].g_bpend.b_r;
      assign c_in_s = g_stage[k-1].c_r;
      assign v_in_s = g_stage[k-1].v_r;
    end

    assign add_s = add_chunk(w_in_s[CW-1:0], b_in_s[CW-1:0], c_in_s);

    if (STAGES == 1) begin : g_rot
      assign w_nxt_s = add_s[CW-1:0];
    end else begin : g_rot
      // Drop the consumed A chunk, insert the new sum chunk at the top.
      assign w_nxt_s = {add_s[CW-1:0], w_in_s[WIDTH-1:CW]};
    end

    // Stage register: rotating sum/operand word, chunk carry and slot valid.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        w_r <= {WIDTH{1'b0}};
        c_r <= 1'b0;
        v_r <= 1'b0;
      end else if (en_s) begin
        w_r <= w_nxt_s;
        c_r <= add_s[CW];
        v_r <= v_in_s;
      end
    end

    if (k < STAGES - 1) begin : g_bpend
      logic [BW-CW-1:0] b_r;

      // Delay the B_eff chunks that later stages still have to add.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          b_r <= {(BW-CW){1'b0}};
        end else if (en_s) begin
          b_r <= b_in_s[BW-1:CW];
        end
      end
    end
  end

  // Signed overflow, judged on the MSB chunk as it enters the last stage.
  always_comb begin
    ovf_nxt_s = (g_stage[STAGES-1].w_in_s[CW-1] == g_stage[STAGES-1].b_in_s[CW-1]) &&
                (g_stage[STAGES-1].add_s[CW-1]  != g_stage[STAGES-1].w_in_s[CW-1]);
  end

  // Overflow flag register, aligned with the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (en_s) begin
      ovf_r <= ovf_nxt_s;
    end
  end

  // Single advance enable: move whenever the output slot is empty or drained.
  assign en_s          = !g_stage[STAGES-1].v_r || bus.out_ready;
  assign bus.in_ready  = en_s;
  assign bus.out_valid = g_stage[STAGES-1].v_r;
  assign bus.Y         = g_stage[STAGES-1].w_r;
  assign bus.Cout      = g_stage[STAGES-1].c_r;
  assign bus.Ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Scoreboard bench for pipelined_carry_adder (WIDTH=16, STAGES=4).
// Stimulus pushes the expected result when an input transfer happens; a
// monitor pops and compares whenever an output transfer happens.
module tb_pipelined_carry_adder;
  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  res_t sb_q[$];
  res_t mon_e;
  bit   bp_seen;

  logic [WIDTH-1:0] sa   [10];
  logic [WIDTH-1:0] sbv  [10];
  logic             scin [10];
  logic             ssub [10];
  res_t             sexp [10];
  bit               bub_exp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  pipelined_carry_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_carry_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk_w(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic res_t mk(input logic [WIDTH-1:0] y, input logic c, input logic o);
    res_t r;
    r.y    = y;
    r.cout = c;
    r.ovf  = o;
    return r;
  endfunction

  // Plain full-width reference add, used for the streamed operand pairs.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    logic [WIDTH-1:0] be;
    logic [WIDTH:0]   s;
    res_t             r;
    be     = sub ? ~b : b;
    s      = {1'b0, a} + {1'b0, be} + {{WIDTH{1'b0}}, (sub ? 1'b1 : cin)};
    r.y    = s[WIDTH-1:0];
    r.cout = s[WIDTH];
    r.ovf  = (a[WIDTH-1] == be[WIDTH-1]) && (r.y[WIDTH-1] != a[WIDTH-1]);
    return r;
  endfunction

  // Present one operand set (called at posedge+1), retry while in_ready=0.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub, input res_t exp);
    bit done;
    done         = 1'b0;
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = cin;
    bus.Sub      = sub;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb_q.push_back(exp);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0 for 50 cycles, expected 1");
    end
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected result has been seen.
  task automatic drain();
    for (int t = 0; t < 100 && sb_q.size() != 0; t++) begin
      @(negedge clk);
      #1;
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results still outstanding, expected 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each output transfer against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got Y=0x%0h, expected no result", bus.Y);
      end else begin
        mon_e = sb_q.pop_front();
        chk_w("Y", bus.Y, mon_e.y);
        chk_b("Cout", bus.Cout, mon_e.cout);
        chk_b("Ovf", bus.Ovf, mon_e.ovf);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.A         = 16'h1357;
    bus.B         = 16'h2468;
    bus.Cin       = 1'b0;
    bus.Sub       = 1'b0;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk_b("rst_out_valid", bus.out_valid, 1'b0);
    chk_w("rst_Y", bus.Y, 16'h0000);
    chk_b("rst_Cout", bus.Cout, 1'b0);
    chk_b("rst_Ovf", bus.Ovf, 1'b0);
    chk_b("rst_in_ready", bus.in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    chk_b("post_rst_in_ready", bus.in_ready, 1'b1);

    // Basic add with latency check.
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, mk(16'h0100, 1'b0, 1'b0));
    repeat (3) begin
      @(negedge clk);
      chk_b("latency_early", bus.out_valid, 1'b0);
    end
    @(negedge clk);
    chk_b("latency_valid", bus.out_valid, 1'b1);
    @(posedge clk);
    #1;

    // Full-width carry, signed overflow, subtract.
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, mk(16'h0000, 1'b1, 1'b0));
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
    send(16'h0005, 16'h0007, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
    send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
    drain();

    // Streaming with backpressure.
    for (int i = 0; i < 10; i++) begin
      sa[i]   = WIDTH'($urandom);
      sbv[i]  = WIDTH'($urandom);
      scin[i] = 1'($urandom);
      ssub[i] = 1'(i % 2);
      sexp[i] = model(sa[i], sbv[i], scin[i], ssub[i]);
    end
    bp_seen = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(sa[i], sbv[i], scin[i], ssub[i], sexp[i]);
      end
      begin
        for (int t = 0; t < 100 && !bp_seen; t++) begin
          @(posedge clk);
          #1;
          if (bus.out_valid) bp_seen = 1'b1;
        end
        if (!bp_seen) begin
          n_cmp++;
          n_err++;
          $display("FAIL stall_wait: out_valid never rose, expected 1");
        end else begin
          bus.out_ready = 1'b0;
          repeat (3) begin
            @(negedge clk);
            chk_b("stall_in_ready", bus.in_ready, 1'b0);
            chk_b("stall_out_valid", bus.out_valid, 1'b1);
            chk_w("stall_Y", bus.Y, sexp[0].y);
            chk_b("stall_Cout", bus.Cout, sexp[0].cout);
          end
          @(posedge clk);
          #1;
          bus.out_ready = 1'b1;
        end
      end
    join
    drain();

    // Bubbles: valid pattern 1,0,1,0 reappears STAGES cycles later.
    send(16'h1111, 16'h2222, 1'b0, 1'b0, mk(16'h3333, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, mk(16'hFFFE, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_b("bubble_valid", bus.out_valid, bub_exp[i]);
    end
    drain();

    // Reset with three operands in flight, before any output.
    send(16'h0001, 16'h0001, 1'b0, 1'b0, mk(16'h0002, 1'b0, 1'b0));
    send(16'h0010, 16'h0020, 1'b0, 1'b0, mk(16'h0030, 1'b0, 1'b0));
    send(16'h0100, 16'h0001, 1'b0, 1'b1, mk(16'h00FF, 1'b1, 1'b0));
    rst_n = 1'b0;
    #1;
    chk_b("midrst_out_valid", bus.out_valid, 1'b0);
    chk_b("midrst_in_ready", bus.in_ready, 1'b1);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk_b("no_stale_valid", bus.out_valid, 1'b0);
    end
    chk_b("release_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Reset while a result is presented: out_valid must drop at once.
    send(16'h0003, 16'h0004, 1'b0, 1'b0, mk(16'h0007, 1'b0, 1'b0));
    send(16'h0005, 16'h0006, 1'b0, 1'b0, mk(16'h000B, 1'b0, 1'b0));
    send(16'h0007, 16'h0008, 1'b0, 1'b0, mk(16'h000F, 1'b0, 1'b0));
    send(16'h0009, 16'h000A, 1'b0, 1'b0, mk(16'h0013, 1'b0, 1'b0));
    chk_b("pre_rst_valid", bus.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_b("async_drop_valid", bus.out_valid, 1'b0);
    chk_w("async_drop_Y", bus.Y, 16'h0000);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Normal operation after reset.
    send(16'h1234, 16'h4321, 1'b0, 1'b0, mk(16'h5555, 1'b0, 1'b0));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipelined_carry_adder.md
Name: pipelined_carry_adder

Overview:
- Parametrised, pipelined successor to the team's 4-bit ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES chunks of ripple-carry logic, with one chunk per pipeline stage and the carry registered between stages.
- Uses valid/ready handshakes on input and output, so it drops into the datapath as a streaming arithmetic unit.
- Adds subtract mode, external carry-in, and a signed-overflow flag.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; also the latency in cycles. Chunk width CW = WIDTH/STAGES. STAGES >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- A  input  WIDTH  operand A (unsigned or two's-complement).
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in; ignored when Sub=1.
- Sub  input  1  0: Y=A+B+Cin; 1: Y=A-B (computed as A+~B+1).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- Y  output  WIDTH  sum/difference, mod 2^WIDTH.
- Cout  output  1  carry out of the MSB (for Sub=1: 1 means no borrow, i.e. A>=B unsigned).
- Ovf  output  1  signed overflow: sign(A)==sign(B_eff) and sign(Y)!=sign(A), where B_eff = Sub ? ~B : B.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits are 0; out_valid=0, Y=0, Cout=0, Ovf=0. in_ready reads 1 during and after reset. Operands are not captured while rst_n is low.
- Global advance enable: en = !out_valid || out_ready. The design uses a single enable; the whole pipeline shifts together. in_ready = en, driven combinationally from out_valid/out_ready only, with no combinational path from in_valid.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - On each en cycle, stage 0 loads in_valid. Bubbles propagate as invalid slots and are not collapsed.
- Stage k (0..STAGES-1), on en:
  - Adds chunk k (bits [k*CW +: CW]) of A and B_eff plus the carry from stage k-1. Stage 0 uses Sub ? 1 : Cin.
  - Registers the CW-bit partial sum and carry.
  - Delays the higher, not-yet-added operand chunks.
  - Delays the already-computed lower sum chunks to stay aligned.
  - Carries the operand MSBs forward for Ovf.
- Latency: a transfer accepted at edge n with out_ready held high gives out_valid=1 with its result after edge n+STAGES-1, i.e. STAGES register stages. Throughput is 1 result per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, every stage register, Y, Cout and Ovf hold their values, and in_ready=0.
- Simultaneous output and input transfer in the same cycle: both occur, and the pipeline advances.
- Arithmetic:
  - Y = (A + B_eff + c0) mod 2^WIDTH.
  - Cout = bit WIDTH of that sum.
  - Ovf = (A[W-1]==B_eff[W-1]) && (Y[W-1]!=A[W-1]).
  - Results are bit-identical to a combinational WIDTH-bit add.
- Valid-low outputs: Y, Cout and Ovf are only meaningful while out_valid=1. Their values when out_valid=0 are don't-care after reset.
- Reset mid-operation: all in-flight results are discarded immediately and out_valid drops asynchronously. No partial result emerges after reset release.
- STAGES=1 degenerates to a single registered ripple adder with latency 1.

Test Plan (WIDTH=16, STAGES=4):
- Basic add: A=0x00FF, B=0x0001, Cin=0, Sub=0, out_ready=1 -> 4 cycles later out_valid=1, Y=0x0100, Cout=0, Ovf=0; no carry lost between chunks.
- Full-width carry: A=0xFFFF, B=0x0000, Cin=1 -> Y=0x0000, Cout=1, Ovf=0. Then A=0x7FFF, B=0x0001, Cin=0 -> Y=0x8000, Cout=0, Ovf=1.
- Subtract: A=0x0005, B=0x0007, Sub=1, Cin=1 (Cin ignored) -> Y=0xFFFE, Cout=0, Ovf=0. Then A=0x8000, B=0x0001, Sub=1 -> Y=0x7FFF, Cout=1, Ovf=1.
- Streaming with backpressure: issue 10 back-to-back random pairs. Hold out_ready=0 for 3 cycles after the first result appears -> in_ready=0 during the stall, results hold stable, and all 10 results arrive in order and match the reference model, with none dropped or duplicated.
- Bubbles: toggle in_valid 1,0,1,0 -> out_valid shows the same 1,0,1,0 pattern shifted by 4 cycles.
- Reset mid-flight: load 3 operands, assert rst_n=0 for 1 cycle before any output -> out_valid=0 immediately, no stale result afterwards, and in_ready=1 after release.
